// File: rtl/rv32i_datapath.sv
// rv32i_datapath: single-cycle RV32I datapath (PC, instruction ROM, register file,
// immediate generator, ALU, branch comparator, byte-addressable data RAM, writeback mux).
// All decode is done by an external control unit that drives the control inputs.
// Optional macro DATAPATH_TRACE_EN adds dbg_pc / dbg_alu / dbg_wd_rf observation ports.
// ROM contents are supplied externally.
module rv32i_datapath #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter string       IMEM_INIT  = "imem.hex",
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Jump,
    input  logic        RE_DMEM,
    input  logic        WE_DMEM,
    input  logic        Branch,
    input  logic        WE_RF,
    input  logic [2:0]  Mode_DMEM,
    input  logic [2:0]  Select_WD_RF,
    input  logic [4:0]  Op_ALU,
    input  logic        Select_PC_RS1,
    input  logic        Select_SrcB_ALU,
    input  logic [2:0]  SignExt_Control,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
`ifdef DATAPATH_TRACE_EN
    ,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_alu,
    output logic [31:0] dbg_wd_rf
`endif
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] rf   [0:31];

    logic [31:0] pc, instr, rs1_val, rs2_val, imm, alu_b, alu_result;
    logic [31:0] pc_plus4, target_sum, target, next_pc;
    logic [31:0] load_word, load_data, store_data, wd_rf;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  store_mask;
    logic        branch_cond;
    logic [IW-1:0] imem_idx;
    logic [DW-1:0] dmem_idx;

    assign imem_idx = pc[IW+1:2];
    assign instr    = imem[imem_idx];
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign rd_addr  = instr[11:7];

    // x0 is hardwired to zero on both read ports
    assign rs1_val = (rs1_addr == 5'd0) ? 32'h0 : rf[rs1_addr];
    assign rs2_val = (rs2_addr == 5'd0) ? 32'h0 : rf[rs2_addr];

    // immediate generator
    always_comb begin
        imm = 32'h0;
        case (SignExt_Control)
            3'd0: imm = {{20{instr[31]}}, instr[31:20]};
            3'd1: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3: imm = {instr[31:12], 12'h0};
            3'd4: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

    assign alu_b = Select_SrcB_ALU ? imm : rs2_val;

    // ALU
    always_comb begin
        alu_result = 32'h0;
        case (Op_ALU)
            5'b11010: alu_result = rs1_val + alu_b;
            5'b00000: alu_result = rs1_val - alu_b;
            5'b11000: alu_result = rs1_val << alu_b[4:0];
            5'b11001: alu_result = rs1_val >> alu_b[4:0];
            5'b11101: alu_result = $signed(rs1_val) >>> alu_b[4:0];
            5'b10000: alu_result = rs1_val | alu_b;
            5'b10001: alu_result = rs1_val & alu_b;
            5'b10010: alu_result = rs1_val ^ alu_b;
            5'b00011: alu_result = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            5'b00010: alu_result = {31'h0, rs1_val < alu_b};
            5'b11111: alu_result = alu_b;
            default:  alu_result = 32'h0;
        endcase
    end

    // branch comparator
    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000: branch_cond = (rs1_val == rs2_val);
            3'b001: branch_cond = (rs1_val != rs2_val);
            3'b100: branch_cond = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: branch_cond = (rs1_val < rs2_val);
            3'b111: branch_cond = (rs1_val >= rs2_val);
            default: branch_cond = 1'b0;
        endcase
    end

    assign pc_plus4   = pc + 32'd4;
    assign target_sum = (Select_PC_RS1 ? rs1_val : pc) + imm;
    assign target     = Select_PC_RS1 ? {target_sum[31:1], 1'b0} : target_sum;
    assign next_pc    = (Jump || (Branch && branch_cond)) ? target : pc_plus4;

    // program counter
    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_PC;
        else       pc <= next_pc;
    end

    // register file write port; reset clears the whole file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (WE_RF && (rd_addr != 5'd0)) begin
            rf[rd_addr] <= wd_rf;
        end
    end

    assign dmem_idx  = alu_result[DW+1:2];
    assign load_word = dmem[dmem_idx];

    // store lane steering: replicate rs2 across lanes, enable only the addressed ones
    always_comb begin
        store_data = rs2_val;
        store_mask = 4'b1111;
        case (Mode_DMEM)
            3'b000, 3'b100: begin
                store_data = {4{rs2_val[7:0]}};
                store_mask = 4'b0001 << alu_result[1:0];
            end
            3'b001, 3'b101: begin
                store_data = {2{rs2_val[15:0]}};
                store_mask = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = rs2_val;
                store_mask = 4'b1111;
            end
        endcase
    end

    // data RAM byte-lane writes; suppressed during reset
    always_ff @(posedge clk) begin
        if (!reset && WE_DMEM) begin
            for (int b = 0; b < 4; b++) begin
                if (store_mask[b]) dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    // load lane extraction and extension
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        shifted   = load_word >> {alu_result[1:0], 3'b000};
        half      = alu_result[1] ? load_word[31:16] : load_word[15:0];
        load_data = 32'h0;
        if (RE_DMEM) begin
            case (Mode_DMEM)
                3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  load_data = {{16{half[15]}}, half};
                3'b100:  load_data = {24'h0, shifted[7:0]};
                3'b101:  load_data = {16'h0, half};
                default: load_data = load_word;
            endcase
        end
    end

    // writeback select
    always_comb begin
        wd_rf = 32'h0;
        case (Select_WD_RF)
            3'd0: wd_rf = alu_result;
            3'd1: wd_rf = load_data;
            3'd2: wd_rf = pc_plus4;
            3'd4: wd_rf = pc + imm;
            3'd5: wd_rf = imm;
            default: wd_rf = 32'h0;
        endcase
    end

`ifdef DATAPATH_TRACE_EN
    assign dbg_pc    = pc;
    assign dbg_alu   = alu_result;
    assign dbg_wd_rf = wd_rf;
`endif

endmodule

// File: tb/tb_rv32i_datapath.sv
// Testbench for rv32i_datapath: the bench acts as control unit, places each instruction
// at the PC it expects, and scores register/PC results after every clock edge.
module tb_rv32i_datapath;
    localparam logic [4:0] ADD = 5'b11010, SUB = 5'b00000, SLL = 5'b11000, SRA = 5'b11101;
    localparam logic [4:0] OR_ = 5'b10000, AND_ = 5'b10001, SLT = 5'b00011, SLTU = 5'b00010;

    logic clk = 1'b0;
    logic reset, Jump, RE_DMEM, WE_DMEM, Branch, WE_RF, Select_PC_RS1, Select_SrcB_ALU;
    logic [2:0] Mode_DMEM, Select_WD_RF, SignExt_Control;
    logic [4:0] Op_ALU;
    logic [6:0] op, funct7;
    logic [2:0] funct3;

    rv32i_datapath #(.IMEM_INIT("")) dut (
        .clk(clk), .reset(reset), .Jump(Jump), .RE_DMEM(RE_DMEM), .WE_DMEM(WE_DMEM),
        .Branch(Branch), .WE_RF(WE_RF), .Mode_DMEM(Mode_DMEM), .Select_WD_RF(Select_WD_RF),
        .Op_ALU(Op_ALU), .Select_PC_RS1(Select_PC_RS1), .Select_SrcB_ALU(Select_SrcB_ALU),
        .SignExt_Control(SignExt_Control), .op(op), .funct3(funct3), .funct7(funct7)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  alu;
        logic        srcb;
        logic [2:0]  ext;
        logic [2:0]  wd;
        logic        we_rf, we_dm, re_dm;
        logic [2:0]  mode;
        logic        br, jmp, sel;
        int          rd;
        logic [31:0] val;
        logic [31:0] npc;
    } vec_t;

    typedef struct {
        string       name;
        int          rd;
        logic [31:0] val;
        logic [31:0] npc;
        logic [16:0] fields;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cur_pc;

    function automatic vec_t mk(string nm, logic [31:0] ins, logic [4:0] alu, logic srcb,
                                logic [2:0] ext, logic [2:0] wd, logic we_rf, logic we_dm,
                                logic re_dm, logic [2:0] mode, logic br, logic jmp, logic sel,
                                int rd, logic [31:0] val, logic [31:0] npc);
        vec_t v;
        v.name = nm; v.instr = ins; v.alu = alu; v.srcb = srcb; v.ext = ext; v.wd = wd;
        v.we_rf = we_rf; v.we_dm = we_dm; v.re_dm = re_dm; v.mode = mode; v.br = br;
        v.jmp = jmp; v.sel = sel; v.rd = rd; v.val = val; v.npc = npc;
        return v;
    endfunction

    // register-writing ALU op (R or I form)
    function automatic vec_t alu_v(string nm, logic [31:0] ins, logic [4:0] alu, logic srcb,
                                   int rd, logic [31:0] val, logic [31:0] npc);
        return mk(nm, ins, alu, srcb, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, rd, val, npc);
    endfunction

    function automatic vec_t ld_v(string nm, logic [31:0] ins, logic [2:0] mode, logic re,
                                  int rd, logic [31:0] val, logic [31:0] npc);
        return mk(nm, ins, ADD, 1'b1, 3'd0, 3'd1, 1'b1, 1'b0, re, mode, 1'b0, 1'b0, 1'b0, rd, val, npc);
    endfunction

    function automatic vec_t st_v(string nm, logic [31:0] ins, logic [2:0] mode, logic [31:0] npc);
        return mk(nm, ins, ADD, 1'b1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, mode, 1'b0, 1'b0, 1'b0, 0, 32'h0, npc);
    endfunction

    function automatic vec_t br_v(string nm, logic [31:0] ins, logic [31:0] npc);
        return mk(nm, ins, SUB, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 0, 32'h0, npc);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic idle_controls();
        Jump = 0; RE_DMEM = 0; WE_DMEM = 0; Branch = 0; WE_RF = 0; Select_PC_RS1 = 0;
        Select_SrcB_ALU = 0; Mode_DMEM = 3'b010; Select_WD_RF = 0; SignExt_Control = 0; Op_ALU = ADD;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [31:0] w;

        vecs.push_back(alu_v("addi x5,10",   32'h00A00293, ADD, 1'b1, 5,  32'd10, 32'h04));
        vecs.push_back(alu_v("addi x11,3",   32'h00300593, ADD, 1'b1, 11, 32'd3,  32'h08));
        vecs.push_back(alu_v("addi x12,4",   32'h00400613, ADD, 1'b1, 12, 32'd4,  32'h0C));
        vecs.push_back(alu_v("addi x13,4",   32'h00400693, ADD, 1'b1, 13, 32'd4,  32'h10));
        vecs.push_back(alu_v("add x10",      32'h00C58533, ADD, 1'b0, 10, 32'd7,  32'h14));
        vecs.push_back(alu_v("or x14",       32'h00C5E733, OR_, 1'b0, 14, 32'd7,  32'h18));
        vecs.push_back(alu_v("sll x7",       32'h00D593B3, SLL, 1'b0, 7,  32'd48, 32'h1C));
        vecs.push_back(alu_v("slt x8",       32'h00C5A433, SLT, 1'b0, 8,  32'd1,  32'h20));
        vecs.push_back(br_v("beq ne",        32'h00B50663, 32'h24));
        vecs.push_back(br_v("beq eq",        32'h00E50663, 32'h30));
        vecs.push_back(mk("jal x1", 32'h010000EF, ADD, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 3'b010,
                          1'b0, 1'b1, 1'b0, 1, 32'h34, 32'h40));
        vecs.push_back(mk("lui x10", 32'h12345537, ADD, 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'b010,
                          1'b0, 1'b0, 1'b0, 10, 32'h12345000, 32'h44));
        vecs.push_back(alu_v("addi x9,0x41", 32'h04100493, ADD, 1'b1, 9, 32'h41, 32'h48));
        vecs.push_back(mk("jalr x0", 32'h00048067, ADD, 1'b1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 3'b010,
                          1'b0, 1'b1, 1'b1, 0, 32'h0, 32'h40));
        vecs.push_back(alu_v("addi x15,-1",  32'hFFF00793, ADD, 1'b1, 15, 32'hFFFFFFFF, 32'h44));
        vecs.push_back(br_v("bltu taken",    32'h00F46463, 32'h4C));
        vecs.push_back(br_v("blt not taken", 32'h00F44463, 32'h50));
        vecs.push_back(alu_v("addi x2,0x100", 32'h10000113, ADD, 1'b1, 2, 32'h100, 32'h54));
        vecs.push_back(st_v("sw x11",        32'h00B12423, 3'b010, 32'h58));
        vecs.push_back(ld_v("lw x10",        32'h00812503, 3'b010, 1'b1, 10, 32'd3, 32'h5C));
        vecs.push_back(alu_v("addi x16,0x80", 32'h08000813, ADD, 1'b1, 16, 32'h80, 32'h60));
        vecs.push_back(st_v("sb x16",        32'h010106A3, 3'b000, 32'h64));
        vecs.push_back(ld_v("lb x17",        32'h00D10883, 3'b000, 1'b1, 17, 32'hFFFFFF80, 32'h68));
        vecs.push_back(ld_v("lbu x18",       32'h00D14903, 3'b100, 1'b1, 18, 32'h80, 32'h6C));
        vecs.push_back(ld_v("lw re=0 x19",   32'h00812983, 3'b010, 1'b0, 19, 32'h0, 32'h70));
        vecs.push_back(alu_v("sub x20",      32'h40B60A33, SUB, 1'b0, 20, 32'd1, 32'h74));
        vecs.push_back(alu_v("sra x21",      32'h40B8DAB3, SRA, 1'b0, 21, 32'hFFFFFFF0, 32'h78));
        vecs.push_back(alu_v("addi x0,5",    32'h00500013, ADD, 1'b1, 0, 32'h0, 32'h7C));
        vecs.push_back(alu_v("and x22",      32'h00C5FB33, AND_, 1'b0, 22, 32'h0, 32'h80));
        vecs.push_back(alu_v("slt x23 neg",  32'h00B7ABB3, SLT, 1'b0, 23, 32'd1, 32'h84));
        vecs.push_back(alu_v("sltu x24",     32'h00B7BC33, SLTU, 1'b0, 24, 32'h0, 32'h88));

        // reset sequence
        idle_controls();
        reset = 1;
        dut.imem[0] = 32'h00A00293;
        @(posedge clk); #1;
        chk("reset pc", dut.pc, 32'h0);
        chk("reset op", {25'h0, op}, 32'h13);
        chk("reset funct3", {29'h0, funct3}, 32'h0);
        chk("reset funct7", {25'h0, funct7}, 32'h0);
        chk("reset x5", dut.rf[5], 32'h0);
        cur_pc = 32'h0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = 0;
            dut.imem[cur_pc[9:2]] = vecs[i].instr;
            Op_ALU = vecs[i].alu; Select_SrcB_ALU = vecs[i].srcb; SignExt_Control = vecs[i].ext;
            Select_WD_RF = vecs[i].wd; WE_RF = vecs[i].we_rf; WE_DMEM = vecs[i].we_dm;
            RE_DMEM = vecs[i].re_dm; Mode_DMEM = vecs[i].mode; Branch = vecs[i].br;
            Jump = vecs[i].jmp; Select_PC_RS1 = vecs[i].sel;
            w = vecs[i].instr;
            sb.push_back('{vecs[i].name, vecs[i].rd, vecs[i].val, vecs[i].npc,
                           {w[31:25], w[14:12], w[6:0]}});
            #1;
            chk({vecs[i].name, " fields"}, {15'h0, funct7, funct3, op}, {15'h0, sb[$].fields});
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard empty at %s", vecs[i].name);
            end else begin
                e = sb.pop_front();
                chk({e.name, " rd"}, dut.rf[e.rd], e.val);
                chk({e.name, " pc"}, dut.pc, e.npc);
                cur_pc = e.npc;
            end
        end

        chk("dmem sw word", dut.dmem[66], 32'd3);
        chk("dmem sb lane", {24'h0, dut.dmem[67][15:8]}, 32'h80);

        // reset overrides a pending register write
        @(negedge clk);
        idle_controls();
        dut.imem[cur_pc[9:2]] = 32'h00500B13;
        Select_SrcB_ALU = 1; WE_RF = 1;
        reset = 1;
        @(posedge clk); #1;
        chk("reset-we pc", dut.pc, 32'h0);
        chk("reset-we x22", dut.rf[22], 32'h0);
        chk("reset-we x11", dut.rf[11], 32'h0);
        chk("reset-we op", {25'h0, op}, 32'h13);
        @(negedge clk);
        reset = 0; WE_RF = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
